// File: rtl/uart_protocol_pkg.sv
// Shared definitions for the ASCII UART bus protocol (host and responder):
// protocol characters, request op encodings, host FSM states, hex helpers.
package uart_protocol_pkg;

  localparam logic [7:0] CH_L   = 8'h4c;  // 'L' load address
  localparam logic [7:0] CH_R   = 8'h52;  // 'R' read
  localparam logic [7:0] CH_W   = 8'h57;  // 'W' write
  localparam logic [7:0] CH_RST = 8'h2a;  // '*' target reset

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RESET = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_L,
    ST_SEND_ADDR,
    ST_SEND_CMD,
    ST_SEND_DATA,
    ST_WAIT_RX,
    ST_SEND_RST,
    ST_RESP
  } host_state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } nib_t;

  // Lower-case hex digit for a nibble.
  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Decode '0'-'9' / 'a'-'f'; anything else comes back with vld=0.
  function automatic nib_t asc2nib(input logic [7:0] c);
    nib_t r;
    r.vld = 1'b0;
    r.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.vld = 1'b1;
      r.nib = c[3:0];
    end else if (c >= 8'h61 && c <= 8'h66) begin
      r.vld = 1'b1;
      r.nib = c[3:0] + 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_protocol_host_if.sv
// Request/response bus between a requester and the UART protocol host.
interface uart_protocol_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_dat;
  logic        rsp_valid;
  logic [7:0]  rsp_dat;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_dat,
    input  req_ready, rsp_valid, rsp_dat, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_dat,
    output req_ready, rsp_valid, rsp_dat, rsp_err
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Sends one pending character into the UART transmitter: strobes only while
// the transmitter is ready, then forces a one-cycle bubble. o_done marks the
// bubble cycle, which is when the owner may move on to the next character.
module uart_tx_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_char,
  input  logic       i_uart_send_ready,
  output logic       o_uart_send_pulse,
  output logic [7:0] o_uart_dat,
  output logic       o_done
);

  logic r_bubble;
  logic w_pulse;

  assign w_pulse           = i_load && i_uart_send_ready && !r_bubble;
  assign o_uart_send_pulse = w_pulse;
  assign o_uart_dat        = i_load ? i_char : 8'h00;
  assign o_done            = r_bubble;

  // Bubble flag: set for exactly the cycle after each strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_bubble <= 1'b0;
    else         r_bubble <= w_pulse;
  end

endmodule

// File: rtl/uart_protocol_host.sv
// Host-side initiator for the ASCII UART bus protocol. Serialises read,
// write and target-reset requests into characters and parses the two-digit
// hex read reply. Optional build macro UART_HOST_ADDR_CACHE_EN skips the
// address phase when the request hits the target's auto-incremented address.
module uart_protocol_host
  import uart_protocol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  uart_protocol_host_if.slave        bus,
  input  logic                       i_uart_send_ready,
  output logic                       o_uart_send_pulse,
  output logic [7:0]                 o_uart_dat,
  input  logic                       i_uart_received_pulse,
  input  logic [7:0]                 i_uart_dat
);

  // Counter value in the last WAIT_RX cycle before timing out; the counter
  // tracks cycles since the 'R' strobe (or since the last accepted digit).
  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  host_state_t r_state, w_next;
  logic [1:0]  r_idx;
  logic [1:0]  r_op;
  logic [15:0] r_addr;
  logic [7:0]  r_dat;
  logic [31:0] r_cnt;
  logic        r_err;
  logic [3:0]  r_hi;
  logic [7:0]  r_rsp_dat;
  logic        w_load, w_done, w_hit, w_accept, w_rx_ok, w_timeout;
  logic [7:0]  w_char;
  logic        w_req_ready, w_rsp_valid;
  nib_t        w_rx;

  assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
  assign w_rx      = asc2nib(i_uart_dat);
  assign w_rx_ok   = (r_state == ST_WAIT_RX) && i_uart_received_pulse && w_rx.vld;
  assign w_timeout = (r_state == ST_WAIT_RX) && !w_rx_ok && (r_cnt >= LP_TO_LAST);

`ifdef UART_HOST_ADDR_CACHE_EN
  logic        r_sh_vld;
  logic [15:0] r_sh;

  // Shadow of the target's auto-incremented address after a good transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sh_vld <= 1'b0;
      r_sh     <= 16'h0000;
    end else if (w_timeout || (r_state == ST_SEND_RST && w_done)) begin
      r_sh_vld <= 1'b0;
    end else if ((r_state == ST_SEND_DATA && w_done && r_idx[0]) ||
                 (w_rx_ok && r_idx[0])) begin
      r_sh_vld <= 1'b1;
      r_sh     <= r_addr + 16'd1;
    end
  end

  assign w_hit = r_sh_vld && (r_sh == bus.req_addr);
`else
  assign w_hit = 1'b0;
`endif

  uart_tx_sequencer u_seq (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_load            (w_load),
    .i_char            (w_char),
    .i_uart_send_ready (i_uart_send_ready),
    .o_uart_send_pulse (o_uart_send_pulse),
    .o_uart_dat        (o_uart_dat),
    .o_done            (w_done)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: each send state advances on the sequencer's bubble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_RSVD)       w_next = ST_RESP;
          else if (bus.req_op == OP_RESET) w_next = ST_SEND_RST;
          else if (w_hit)                  w_next = ST_SEND_CMD;
          else                             w_next = ST_SEND_L;
        end
      end
      ST_SEND_L:    if (w_done) w_next = ST_SEND_ADDR;
      ST_SEND_ADDR: if (w_done && r_idx == 2'd3) w_next = ST_SEND_CMD;
      ST_SEND_CMD:  if (w_done) w_next = (r_op == OP_WRITE) ? ST_SEND_DATA : ST_WAIT_RX;
      ST_SEND_DATA: if (w_done && r_idx[0]) w_next = ST_RESP;
      ST_WAIT_RX:   if ((w_rx_ok && r_idx[0]) || w_timeout) w_next = ST_RESP;
      ST_SEND_RST:  if (w_done) w_next = ST_RESP;
      ST_RESP:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Output logic: character selection and handshake flags per state.
  always_comb begin
    w_load      = 1'b0;
    w_char      = 8'h00;
    w_req_ready = (r_state == ST_IDLE);
    w_rsp_valid = (r_state == ST_RESP);
    case (r_state)
      ST_SEND_L: begin
        w_load = 1'b1;
        w_char = CH_L;
      end
      ST_SEND_ADDR: begin
        w_load = 1'b1;
        w_char = nib2asc(r_addr[{r_idx, 2'b00} +: 4]);
      end
      ST_SEND_CMD: begin
        w_load = 1'b1;
        w_char = (r_op == OP_READ) ? CH_R : CH_W;
      end
      ST_SEND_DATA: begin
        w_load = 1'b1;
        w_char = nib2asc(r_idx[0] ? r_dat[7:4] : r_dat[3:0]);
      end
      ST_SEND_RST: begin
        w_load = 1'b1;
        w_char = CH_RST;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_err   = w_rsp_valid && r_err;
  assign bus.rsp_dat   = r_rsp_dat;

  // Control: character index, reply timeout counter, error flag, read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx     <= 2'd0;
      r_cnt     <= 32'd0;
      r_err     <= 1'b0;
      r_rsp_dat <= 8'h00;
    end else begin
      if (w_next != r_state) r_idx <= 2'd0;
      else if ((w_done && (r_state == ST_SEND_ADDR || r_state == ST_SEND_DATA)) || w_rx_ok)
        r_idx <= r_idx + 2'd1;

      // Two cycles (strobe + bubble) have elapsed when WAIT_RX is entered.
      if (r_state == ST_SEND_CMD)     r_cnt <= 32'd2;
      else if (w_rx_ok)               r_cnt <= 32'd1;
      else if (r_state == ST_WAIT_RX) r_cnt <= r_cnt + 32'd1;

      if (w_accept)       r_err <= (bus.req_op == OP_RSVD);
      else if (w_timeout) r_err <= 1'b1;

      if (w_rx_ok && r_idx[0]) r_rsp_dat <= {r_hi, w_rx.nib};
    end
  end

  // Request capture and first (high) reply nibble.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op   <= bus.req_op;
      r_addr <= bus.req_addr;
      r_dat  <= bus.req_dat;
    end
    if (w_rx_ok && !r_idx[0]) r_hi <= w_rx.nib;
  end

endmodule

// File: doc/uart_protocol_host.md
Name: uart_protocol_host

Overview:
Host-side initiator for the ASCII UART bus protocol (L<addr>, W<data>, R, *). It accepts single-byte bus requests on a valid/ready interface and serialises each one into protocol characters for a UART transmitter. For reads it parses the two returned hex characters into a byte. It is the counterpart of the on-target protocol responder and is used in FPGA-to-FPGA links and in the simulation host model.

Parameters:
TIMEOUT_CYCLES, 100000, clocks to wait for read-response characters before flagging an error; 32-bit counter.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  block idle, request accepted when valid&&ready
i_req_op  in  2  0=read, 1=write, 2=target reset ('*'), 3=reserved
i_req_addr  in  16  bus address
i_req_dat  in  8  write data
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_dat  out  8  read data (held until next completion)
o_rsp_err  out  1  qualified by o_rsp_valid: timeout or reserved op
i_uart_send_ready  in  1  transmitter can take a character
o_uart_send_pulse  out  1  one-cycle strobe, character on o_uart_dat
o_uart_dat  out  8  character to send
i_uart_received_pulse  in  1  received character strobe
i_uart_dat  in  8  received character

Behaviour:
- Reset: state IDLE; o_req_ready=1; o_rsp_valid=0; o_rsp_err=0; o_rsp_dat=0; o_uart_send_pulse=0; o_uart_dat=0; shadow address invalid. A reset mid-transaction abandons it with no response.
- Wire format: lower-case hex only. Address is 4 chars, low nibble first. Write data is 2 chars, low nibble first. Read response is 2 chars, high nibble first.
- Nibble to ASCII: 0-9 map to 0x30+n; 10-15 map to 0x57+n.
- TX rule: o_uart_send_pulse is asserted only in a cycle where i_uart_send_ready=1, with o_uart_dat valid in that same cycle. The FSM advances one character per pulse and never sends two characters in consecutive cycles (one bubble after each pulse).
- FSM states: IDLE, SEND_L, SEND_ADDR(idx 0..3), SEND_CMD, SEND_DATA(idx 0..1), WAIT_RX(idx 0..1), SEND_RST, RESP.
- IDLE: on accept, latch op, address and data. Op 3 goes to RESP with err=1. Op 2 goes to SEND_RST. Ops 0/1 go to SEND_L.
- SEND_L sends 'L', then SEND_ADDR sends 4 chars, then SEND_CMD.
- SEND_CMD sends 'W' (followed by SEND_DATA) or 'R' (followed by WAIT_RX).
- SEND_DATA: after the 2nd character, go to RESP.
- WAIT_RX: accepts only hex characters 0-9 and a-f. Other received characters are dropped and do not advance idx. Idx 0 fills o_rsp_dat[7:4], idx 1 fills [3:0], then go to RESP.
- WAIT_RX timeout: a counter clears on entry and on each accepted character. Reaching TIMEOUT_CYCLES goes to RESP with err=1 and invalidates the shadow address.
- SEND_RST sends '*', goes to RESP, and invalidates the shadow address.
- RESP: o_rsp_valid=1 for one cycle, then IDLE. o_req_ready=1 only in IDLE.
- Received characters outside WAIT_RX are ignored.
- Shadow address: after a successful read or write it is set to latched address + 1, wrapping 0xffff to 0x0000. It is only consumed under the optional feature.
- Latency, write with all TX ready: 1 + 2×(1+4+1+2) cycles until o_rsp_valid = 17.

Optional Feature:
UART_HOST_ADDR_CACHE_EN
- Defined: for ops 0/1, if the shadow address is valid and equals i_req_addr, skip SEND_L/SEND_ADDR and go directly to SEND_CMD. This exploits the target's auto-increment.
- Undefined: the L+4 address characters are always sent, and the shadow address logic may be optimised away.

Decomposition:
- Shared package uart_protocol_pkg holds:
  - character constants CH_L, CH_R, CH_W, CH_RST;
  - OP_READ, OP_WRITE, OP_RESET encodings;
  - nibble-to-ASCII and ASCII-to-nibble (with valid flag) functions, also used by the responder.
- One natural sub-module: uart_tx_sequencer, which owns the send_ready/pulse handshake and the one-bubble spacing for a single pending character.

Test Plan:
- Write 0x1a00 ← 0x4d with TX always ready -> characters 'L','0','0','a','1','W','d','4'; o_rsp_valid with err=0 at cycle 17.
- Read 0x1234, bench replies '3','c' -> characters 'L','4','3','2','1','R'; o_rsp_dat=0x3c, err=0.
- Read with reply 'x','\n','f','0' -> junk ignored; o_rsp_dat=0xf0.
- Read with no reply, TIMEOUT_CYCLES=50 -> o_rsp_valid with err=1 exactly 50 cycles after 'R'; next request resends 'L'.
- Op 2 -> single '*' and completion. Op 3 -> no characters, err=1. Toggling i_uart_send_ready 1:3 -> no pulse while ready is low.
- With UART_HOST_ADDR_CACHE_EN: write 0xffff then read 0x0000 -> second transaction emits only 'R'. i_reset mid-address -> o_req_ready=1 next cycle, no o_rsp_valid.
